// File: rtl/glitch_payload_sequencer.sv
// glitch_payload_sequencer
//   Runs a sweep of glitch attempts against a target. Each attempt waits a
//   programmable offset and then drops target power for a programmable width.
//   It then sends a RAM-held payload over 8N1 UART (LSB first) and keeps the
//   target powered for a cooldown. Between attempts the offset advances by a
//   step, which wraps modulo 2^OFFSET_W.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   start, abort      sweep control pulses (abort wins over start)
//   cfg_*             sweep configuration, captured when start is accepted
//   pl_wr_*           payload RAM write port (writes ignored while busy)
//   trig              external trigger (only with GLITCH_EXT_TRIGGER_EN)
//   power_tx          target power enable, 1 = powered
//   uart_tx           UART line to target, idle high
//   busy, done        sweep in progress / one-cycle completion pulse
//   attempt_idx       0-based attempt number
//   cur_offset        offset used by the current attempt
//
// Build option
//   GLITCH_EXT_TRIGGER_EN: after ARM, each attempt waits for a rising edge of
//   the 2-flop synchronised trig input before starting its offset delay.
module glitch_payload_sequencer #(
    parameter int unsigned DELAY_FRAMES   = 234,
    parameter int unsigned PAYLOAD_DEPTH  = 16,
    parameter int unsigned OFFSET_W       = 24,
    parameter int unsigned WIDTH_W        = 16,
    parameter int unsigned RECOVER_CYCLES = 1024
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic                                 abort,
    input  logic [OFFSET_W-1:0]                  cfg_offset,
    input  logic [OFFSET_W-1:0]                  cfg_step,
    input  logic [WIDTH_W-1:0]                   cfg_width,
    input  logic [7:0]                           cfg_attempts,
    input  logic [$clog2(PAYLOAD_DEPTH+1)-1:0]   cfg_len,
    input  logic                                 pl_wr_en,
    input  logic [$clog2(PAYLOAD_DEPTH)-1:0]     pl_wr_addr,
    input  logic [7:0]                           pl_wr_data,
`ifdef GLITCH_EXT_TRIGGER_EN
    input  logic                                 trig,
`endif
    output logic                                 power_tx,
    output logic                                 uart_tx,
    output logic                                 busy,
    output logic                                 done,
    output logic [7:0]                           attempt_idx,
    output logic [OFFSET_W-1:0]                  cur_offset
);

    localparam int unsigned LEN_W  = $clog2(PAYLOAD_DEPTH + 1);
    localparam int unsigned ADDR_W = $clog2(PAYLOAD_DEPTH);
    localparam int unsigned CW_A   = (OFFSET_W > WIDTH_W) ? OFFSET_W : WIDTH_W;
    localparam int unsigned CW_R   = $clog2(RECOVER_CYCLES + 1);
    localparam int unsigned CW_D   = $clog2(DELAY_FRAMES + 1);
    localparam int unsigned CW_B   = (CW_R > CW_D) ? CW_R : CW_D;
    localparam int unsigned CNT_W  = (CW_A > CW_B) ? CW_A : CW_B;

    localparam logic [CNT_W-1:0] DF_LAST = CNT_W'(DELAY_FRAMES - 1);
    localparam logic [CNT_W-1:0] RC_LAST = CNT_W'(RECOVER_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
`ifdef GLITCH_EXT_TRIGGER_EN
        S_WAIT_TRIG,
`endif
        S_DELAY,
        S_GLITCH,
        S_TX,
        S_RECOVER,
        S_DONE
    } state_t;

    state_t                state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [OFFSET_W-1:0]   cur_offset_q;
    logic [OFFSET_W-1:0]   step_q;
    logic [WIDTH_W-1:0]    width_q;
    logic [7:0]            attempts_q;
    logic [7:0]            attempt_idx_q;
    logic [LEN_W-1:0]      len_q;
    logic [LEN_W-1:0]      byte_idx_q;
    logic [3:0]            bit_idx_q;
    logic [7:0]            tx_byte_q;
    logic                  power_tx_q;
    logic                  uart_tx_q;
    logic                  busy_q;
    logic                  done_q;
    logic [7:0]            ram_q [PAYLOAD_DEPTH];

    logic                  launch_d;
    logic                  enter_pd_d;
    state_t                post_glitch_st_d;
    logic [CNT_W-1:0]      post_glitch_cnt_d;
    state_t                post_delay_st_d;
    logic [CNT_W-1:0]      post_delay_cnt_d;
    logic [ADDR_W-1:0]     byte_next_d;

`ifdef GLITCH_EXT_TRIGGER_EN
    logic [2:0] trig_sync_q;
    logic       trig_rise;

    always_ff @(posedge clk) begin
        if (rst) trig_sync_q <= '0;
        else     trig_sync_q <= {trig_sync_q[1:0], trig};
    end

    assign trig_rise = trig_sync_q[1] & ~trig_sync_q[2];
`endif

    // Where each phase hands over to when its own length is zero; lets a zero
    // offset, width or length skip straight through in the same cycle.
    always_comb begin
`ifdef GLITCH_EXT_TRIGGER_EN
        launch_d = (state_q == S_WAIT_TRIG) && trig_rise;
`else
        launch_d = (state_q == S_ARM);
`endif
        enter_pd_d = (launch_d && (cur_offset_q == '0)) ||
                     ((state_q == S_DELAY) && (cnt_q == '0));

        if (len_q != '0) begin
            post_glitch_st_d  = S_TX;
            post_glitch_cnt_d = DF_LAST;
        end else begin
            post_glitch_st_d  = S_RECOVER;
            post_glitch_cnt_d = RC_LAST;
        end

        if (width_q != '0) begin
            post_delay_st_d  = S_GLITCH;
            post_delay_cnt_d = CNT_W'(width_q - 1'b1);
        end else begin
            post_delay_st_d  = post_glitch_st_d;
            post_delay_cnt_d = post_glitch_cnt_d;
        end

        byte_next_d = ADDR_W'(byte_idx_q + 1'b1);
    end

    always_ff @(posedge clk) begin
        if (pl_wr_en && !busy_q && (32'(pl_wr_addr) < PAYLOAD_DEPTH))
            ram_q[pl_wr_addr] <= pl_wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            cur_offset_q  <= '0;
            step_q        <= '0;
            width_q       <= '0;
            attempts_q    <= 8'd1;
            attempt_idx_q <= '0;
            len_q         <= '0;
            byte_idx_q    <= '0;
            bit_idx_q     <= '0;
            tx_byte_q     <= '0;
            power_tx_q    <= 1'b1;
            uart_tx_q     <= 1'b1;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else if (abort) begin
            state_q    <= S_IDLE;
            power_tx_q <= 1'b1;
            uart_tx_q  <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else if (enter_pd_d) begin
            state_q    <= post_delay_st_d;
            cnt_q      <= post_delay_cnt_d;
            power_tx_q <= (post_delay_st_d != S_GLITCH);
            uart_tx_q  <= (post_delay_st_d != S_TX);
            byte_idx_q <= '0;
            bit_idx_q  <= '0;
            tx_byte_q  <= ram_q[0];
        end else if (launch_d) begin
            state_q <= S_DELAY;
            cnt_q   <= CNT_W'(cur_offset_q - 1'b1);
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q       <= S_ARM;
                        busy_q        <= 1'b1;
                        cur_offset_q  <= cfg_offset;
                        step_q        <= cfg_step;
                        width_q       <= cfg_width;
                        attempts_q    <= (cfg_attempts == 8'd0) ? 8'd1 : cfg_attempts;
                        len_q         <= (cfg_len > LEN_W'(PAYLOAD_DEPTH)) ?
                                         LEN_W'(PAYLOAD_DEPTH) : cfg_len;
                        attempt_idx_q <= '0;
                    end
                end
`ifdef GLITCH_EXT_TRIGGER_EN
                S_ARM: state_q <= S_WAIT_TRIG;
`endif
                S_DELAY: cnt_q <= cnt_q - 1'b1;
                S_GLITCH: begin
                    if (cnt_q == '0) begin
                        state_q    <= post_glitch_st_d;
                        cnt_q      <= post_glitch_cnt_d;
                        power_tx_q <= 1'b1;
                        uart_tx_q  <= (post_glitch_st_d != S_TX);
                        byte_idx_q <= '0;
                        bit_idx_q  <= '0;
                        tx_byte_q  <= ram_q[0];
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_TX: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else if (bit_idx_q == 4'd9) begin
                        // Stop bit finished: chain the next byte with no gap.
                        if (byte_idx_q == len_q - 1'b1) begin
                            state_q   <= S_RECOVER;
                            cnt_q     <= RC_LAST;
                            uart_tx_q <= 1'b1;
                        end else begin
                            cnt_q      <= DF_LAST;
                            byte_idx_q <= byte_idx_q + 1'b1;
                            tx_byte_q  <= ram_q[byte_next_d];
                            bit_idx_q  <= '0;
                            uart_tx_q  <= 1'b0;
                        end
                    end else begin
                        // Slot k+1 carries data bit k; slot 9 is the stop bit.
                        cnt_q     <= DF_LAST;
                        bit_idx_q <= bit_idx_q + 1'b1;
                        uart_tx_q <= (bit_idx_q < 4'd8) ? tx_byte_q[bit_idx_q[2:0]] : 1'b1;
                    end
                end
                S_RECOVER: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else if (attempt_idx_q == attempts_q - 8'd1) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q       <= S_ARM;
                        attempt_idx_q <= attempt_idx_q + 8'd1;
                        cur_offset_q  <= cur_offset_q + step_q;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign power_tx    = power_tx_q;
    assign uart_tx     = uart_tx_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign attempt_idx = attempt_idx_q;
    assign cur_offset  = cur_offset_q;

endmodule

// File: tb/tb_glitch_payload_sequencer.sv
// Testbench for glitch_payload_sequencer: expected per-cycle outputs of each
// sweep are generated from the timeline of phases (arm, offset, glitch, UART
// frames, cooldown, done) and compared with the DUT every cycle.
module tb_glitch_payload_sequencer;

    localparam int DF    = 4;
    localparam int DEPTH = 16;
    localparam int OW    = 8;
    localparam int WW    = 8;
    localparam int RC    = 20;
    localparam int OMOD  = 1 << OW;

    typedef struct packed {
        logic       p;
        logic       u;
        logic       b;
        logic       d;
        logic [7:0] idx;
        logic [7:0] off;
    } obs_t;

    localparam obs_t RESET_OBS = '{p: 1'b1, u: 1'b1, b: 1'b0, d: 1'b0, idx: 8'd0, off: 8'd0};

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic [OW-1:0] cfg_offset;
    logic [OW-1:0] cfg_step;
    logic [WW-1:0] cfg_width;
    logic [7:0]    cfg_attempts;
    logic [4:0]    cfg_len;
    logic          pl_wr_en;
    logic [3:0]    pl_wr_addr;
    logic [7:0]    pl_wr_data;
    logic          power_tx;
    logic          uart_tx;
    logic          busy;
    logic          done;
    logic [7:0]    attempt_idx;
    logic [OW-1:0] cur_offset;
`ifdef GLITCH_EXT_TRIGGER_EN
    logic          trig = 1'b0;
`endif

    int   checks   = 0;
    int   failures = 0;
    logic [7:0] mram [DEPTH];
    obs_t exp_q [$];

    always #5 clk = ~clk;

    glitch_payload_sequencer #(
        .DELAY_FRAMES  (DF),
        .PAYLOAD_DEPTH (DEPTH),
        .OFFSET_W      (OW),
        .WIDTH_W       (WW),
        .RECOVER_CYCLES(RC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .cfg_offset  (cfg_offset),
        .cfg_step    (cfg_step),
        .cfg_width   (cfg_width),
        .cfg_attempts(cfg_attempts),
        .cfg_len     (cfg_len),
        .pl_wr_en    (pl_wr_en),
        .pl_wr_addr  (pl_wr_addr),
        .pl_wr_data  (pl_wr_data),
`ifdef GLITCH_EXT_TRIGGER_EN
        .trig        (trig),
`endif
        .power_tx    (power_tx),
        .uart_tx     (uart_tx),
        .busy        (busy),
        .done        (done),
        .attempt_idx (attempt_idx),
        .cur_offset  (cur_offset)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic obs_t sample();
        obs_t o;
        o.p = power_tx; o.u = uart_tx; o.b = busy; o.d = done;
        o.idx = attempt_idx; o.off = cur_offset;
        return o;
    endfunction

    task automatic chk(input string tag, input int cyc, input logic [31:0] obs,
                       input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, expv);
        end
    endtask

    task automatic wr(input int addr, input logic [7:0] data);
        pl_wr_en = 1'b1; pl_wr_addr = 4'(addr); pl_wr_data = data;
        tick();
        pl_wr_en = 1'b0;
        mram[addr] = data;
    endtask

    task automatic quiet();
        start = 1'b0; pl_wr_en = 1'b0;
    endtask

    // Things a host might do mid-sweep that must have no effect.
    task automatic disturb();
        start        = ($urandom_range(0, 7) == 0);
        pl_wr_en     = 1'($urandom_range(0, 1));
        pl_wr_addr   = 4'($urandom);
        pl_wr_data   = 8'($urandom);
        cfg_offset   = 8'($urandom);
        cfg_step     = 8'($urandom);
        cfg_width    = 8'($urandom);
        cfg_attempts = 8'($urandom);
        cfg_len      = 5'($urandom);
    endtask

    // Expected outputs from cycle 1 (first cycle after start) to the idle
    // cycle following the done pulse.
    task automatic build_exp(input int off0, input int step, input int w,
                             input int att, input int len);
        int n;
        int l;
        int off;
        obs_t e;
        logic [9:0] frame;
        n = (att == 0) ? 1 : att;
        l = (len > DEPTH) ? DEPTH : len;
        off = off0 % OMOD;
        exp_q.delete();
        e = '{p: 1'b1, u: 1'b1, b: 1'b1, d: 1'b0, idx: 8'd0, off: 8'd0};
        for (int a = 0; a < n; a++) begin
            e.idx = 8'(a);
            e.off = 8'(off);
            exp_q.push_back(e);                      // arm
            repeat (off) exp_q.push_back(e);         // offset delay
            e.p = 1'b0;
            repeat (w) exp_q.push_back(e);           // glitch
            e.p = 1'b1;
            for (int i = 0; i < l; i++) begin
                frame = {1'b1, mram[i], 1'b0};
                for (int k = 0; k < 10; k++) begin
                    e.u = frame[k];
                    repeat (DF) exp_q.push_back(e);
                end
            end
            e.u = 1'b1;
            repeat (RC) exp_q.push_back(e);          // cooldown
            if (a < n - 1) off = (off + step) % OMOD;
        end
        e.d = 1'b1;
        exp_q.push_back(e);
        e.d = 1'b0;
        e.b = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic run_sweep(input string tag, input int off, input int step,
                             input int w, input int att, input int len,
                             input int abort_at);
        obs_t e;
        build_exp(off, step, w, att, len);
        cfg_offset = 8'(off); cfg_step = 8'(step); cfg_width = 8'(w);
        cfg_attempts = 8'(att); cfg_len = 5'(len);
        pl_wr_en = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= exp_q.size(); c++) begin
            e = exp_q[c-1];
            chk(tag, c, sample(), e);
            if (e.b) disturb();
            else     quiet();
            if (c == abort_at) begin
                abort = 1'b1;
                tick();
                abort = 1'b0;
                quiet();
                chk({tag, "_pwr"},  c + 1, 32'(power_tx), 32'd1);
                chk({tag, "_uart"}, c + 1, 32'(uart_tx),  32'd1);
                chk({tag, "_busy"}, c + 1, 32'(busy),     32'd0);
                chk({tag, "_done"}, c + 1, 32'(done),     32'd0);
                for (int k = 0; k < 40; k++) begin
                    tick();
                    chk({tag, "_quiet"}, c + 2 + k, {30'd0, busy, done}, 32'd0);
                end
                return;
            end
            tick();
        end
        quiet();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        cfg_offset = '0; cfg_step = '0; cfg_width = '0; cfg_attempts = '0; cfg_len = '0;
        pl_wr_en = 1'b0; pl_wr_addr = '0; pl_wr_data = '0;
        repeat (3) tick();
        chk("reset", 0, sample(), RESET_OBS);
        rst = 1'b0;
        tick();

        for (int i = 0; i < DEPTH; i++) wr(i, (i < 4) ? 8'h5D : 8'($urandom));

        run_sweep("basic",        10, 0, 3, 1, 4, 0);
        run_sweep("multi",       100, 5, 4, 3, 2, 0);
        run_sweep("no_glitch_tx", 30, 7, 0, 1, 0, 0);
        run_sweep("offset0",       0, 3, 2, 2, 1, 0);
        // abort lands in bit 3 of byte 1: 2 + offset + width + 40 + 3*DF
        run_sweep("abort",         5, 0, 2, 1, 3, 2 + 5 + 2 + 40 + 3 * DF);
        run_sweep("after_abort",   8, 0, 2, 1, 2, 0);

        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("start_abort", 1, 32'(busy), 32'd0);
        tick();
        chk("start_abort", 2, 32'(busy), 32'd0);

        run_sweep("wrap",      OMOD - 2, 4, 1, 2, 1, 0);
        run_sweep("readback",  3, 0, 1, 1, 20, 0);

        for (int r = 0; r < 6; r++) begin
            if (r % 2 == 1) wr($urandom_range(0, DEPTH - 1), 8'($urandom));
            run_sweep("random", $urandom_range(0, 40), $urandom_range(0, 255),
                      $urandom_range(0, 6), $urandom_range(0, 3),
                      $urandom_range(0, 20), 0);
        end

        cfg_offset = 8'd6; cfg_step = 8'd9; cfg_width = 8'd3;
        cfg_attempts = 8'd2; cfg_len = 5'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (25) tick();
        rst = 1'b1;
        tick();
        chk("rst_mid", 0, sample(), RESET_OBS);
        rst = 1'b0;
        tick();
        run_sweep("post_rst", 4, 1, 1, 1, 3, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
